// File: rtl/bf16_mac_accum_pkg.sv
// -----------------------------------------------------------------------------
// bf16_pkg
// Shared definitions for the bfloat16 MAC accumulator:
//   - bf16 field widths, exponent bias and derived datapath widths
//   - error code constants (ERR_NONE / ERR_OVF / ERR_UNF)
//   - accumulator FSM state enum
//   - bf16 field struct, zero-detect and sticky-error encode helpers
// -----------------------------------------------------------------------------
package bf16_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int EXP_WIDTH   = 8;
    localparam int FRAC_WIDTH  = 7;
    localparam int ERROR_WIDTH = 2;
    localparam int CNT_WIDTH   = 8;
    localparam int EXP_BIAS    = 127;

    // Significand with the hidden one, and the adder result with its carry bit.
    localparam int SIG_WIDTH = FRAC_WIDTH + 1;
    localparam int SUM_WIDTH = SIG_WIDTH + 1;
    // Enough bits to count up to SUM_WIDTH leading zeros.
    localparam int LZC_WIDTH = $clog2(SUM_WIDTH + 1);
    // Normalised exponent carries a sign and one overflow bit.
    localparam int EXP_EXT   = EXP_WIDTH + 2;

    localparam logic [ERROR_WIDTH-1:0] ERR_NONE = 2'b00;
    localparam logic [ERROR_WIDTH-1:0] ERR_OVF  = 2'b01;
    localparam logic [ERROR_WIDTH-1:0] ERR_UNF  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_NORM,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [FRAC_WIDTH-1:0] frac;
    } bf16_t;

    // Exact zero regardless of sign; exponent-0 values with a non-zero
    // fraction are not zero (there are no subnormals here).
    function automatic logic is_zero(input bf16_t v);
        return (v.exp == '0) && (v.frac == '0);
    endfunction

    // Underflow wins over overflow when both have been seen.
    function automatic logic [ERROR_WIDTH-1:0] encode_err(input logic [ERROR_WIDTH-1:0] sticky);
        if (sticky[1]) begin
            return ERR_UNF;
        end else if (sticky[0]) begin
            return ERR_OVF;
        end
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/bf16_mac_accum_if.sv
// -----------------------------------------------------------------------------
// bf16_mac_accum_if
// Term input and result output channels of the bf16 MAC accumulator.
//   in_valid/in_ready  : term handshake; in_data, in_error, in_last ride with it
//   out_valid/out_ready: result handshake; out_data, out_error, out_count ride with it
// Modports:
//   master : upstream producer / downstream consumer side (drives terms, out_ready)
//   slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface bf16_mac_accum_if;
    import bf16_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [ERROR_WIDTH-1:0] in_error;
    logic                   in_last;

    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [ERROR_WIDTH-1:0] out_error;
    logic [CNT_WIDTH-1:0]   out_count;

    modport master (
        output in_valid, in_data, in_error, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_error, out_count
    );

    modport slave (
        input  in_valid, in_data, in_error, in_last, out_ready,
        output in_ready, out_valid, out_data, out_error, out_count
    );

endinterface

// File: rtl/bf16_lzc_norm.sv
// -----------------------------------------------------------------------------
// bf16_lzc_norm
// Combinational leading-zero count and left shift of the 9-bit adder result.
// Ports:
//   sig_i  : 9-bit unsigned significand sum (bit 8 is the carry position)
//   lzc_o  : number of leading zeros in sig_i (SUM_WIDTH when sig_i is zero)
//   frac_o : stored fraction after shifting the leading one up to bit 8
//            (bits [7:1] of the shifted value; bit 0 is truncated away)
//   zero_o : sig_i is all zeros
// -----------------------------------------------------------------------------
module bf16_lzc_norm
    import bf16_pkg::*;
(
    input  logic [SUM_WIDTH-1:0]  sig_i,
    output logic [LZC_WIDTH-1:0]  lzc_o,
    output logic [FRAC_WIDTH-1:0] frac_o,
    output logic                  zero_o
);

    // NOTE: every variable written in an always_comb gets a default on entry,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        lzc_o = LZC_WIDTH'(SUM_WIDTH);
        // Scanning upward lets the most significant set bit win.
        for (int i = 0; i < SUM_WIDTH; i++) begin
            if (sig_i[i]) begin
                lzc_o = LZC_WIDTH'(SUM_WIDTH - 1 - i);
            end
        end
    end

    assign frac_o = FRAC_WIDTH'((sig_i << lzc_o) >> 1);
    assign zero_o = (sig_i == '0);

endmodule

// File: rtl/bf16_mac_accum.sv
// -----------------------------------------------------------------------------
// bf16_mac_accum
// Accumulates a stream of bf16 products into a bf16 running sum using
// truncating arithmetic with no subnormals, and reports the sum, a sticky
// error code and a saturating term count after the term flagged last.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; aborts any partial sum
//   mac_if : bf16_mac_accum_if.slave (term input and result output channels)
//
// Each term takes three cycles: IDLE (accept), ALIGN (align and add),
// NORM (normalise, write accumulator). After the last term the FSM sits in
// DONE; the result registers load on the first DONE cycle and out_valid is
// raised from them, so out_valid follows the last handshake by three edges.
//
// Build option: BF16_MAC_UNDERFLOW_FLUSH_EN -- when defined, a term accepted
// with in_error == ERR_UNF is replaced by +0 (the underflow still sticks).
// -----------------------------------------------------------------------------
module bf16_mac_accum
    import bf16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    bf16_mac_accum_if.slave    mac_if
);

    localparam logic signed [EXP_EXT-1:0] EXP_OVF_LIM = EXP_EXT'((2 ** EXP_WIDTH) - 1);
    localparam logic signed [EXP_EXT-1:0] EXP_UNF_LIM = '0;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e                 state_q,     state_d;
    bf16_t                  acc_q,       acc_d;
    bf16_t                  opnd_q,      opnd_d;
    logic                   last_q,      last_d;
    logic [ERROR_WIDTH-1:0] sticky_q,    sticky_d;
    logic [CNT_WIDTH-1:0]   cnt_q,       cnt_d;

    // ALIGN -> NORM pipeline registers.
    logic [SUM_WIDTH-1:0]   sum_q,       sum_d;
    logic [EXP_WIDTH-1:0]   exp_q,       exp_d;
    logic                   sign_q,      sign_d;
    logic                   byp_q,       byp_d;

    // Result registers.
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;
    logic [ERROR_WIDTH-1:0] out_error_q, out_error_d;
    logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;

    logic                   in_ready_c;

    // ---------------------------------------------------------------------
    // Alignment / add datapath (consumed in ALIGN)
    // ---------------------------------------------------------------------
    bf16_t                  op_a;
    bf16_t                  op_b;
    logic [EXP_WIDTH-1:0]   exp_diff;
    logic [SIG_WIDTH-1:0]   sig_a;
    logic [SIG_WIDTH-1:0]   sig_b_al;
    logic [SUM_WIDTH-1:0]   add_mag;
    logic                   add_sign;

    always_comb begin
        // op_a has the larger (or equal) exponent; ties keep the accumulator as A.
        if (opnd_q.exp > acc_q.exp) begin
            op_a = opnd_q;
            op_b = acc_q;
        end else begin
            op_a = acc_q;
            op_b = opnd_q;
        end

        exp_diff = op_a.exp - op_b.exp;
        sig_a    = {1'b1, op_a.frac};
        sig_b_al = (exp_diff >= EXP_WIDTH'(SUM_WIDTH)) ? '0
                                                        : ({1'b1, op_b.frac} >> exp_diff);

        if (op_a.sign == op_b.sign) begin
            add_mag  = {1'b0, sig_a} + {1'b0, sig_b_al};
            add_sign = op_a.sign;
        end else if (sig_a >= sig_b_al) begin
            add_mag  = {1'b0, sig_a} - {1'b0, sig_b_al};
            add_sign = op_a.sign;
        end else begin
            // Only reachable with equal exponents and a larger B fraction.
            add_mag  = {1'b0, sig_b_al} - {1'b0, sig_a};
            add_sign = op_b.sign;
        end
    end

    // ---------------------------------------------------------------------
    // Normalisation datapath (consumed in NORM)
    // ---------------------------------------------------------------------
    logic [LZC_WIDTH-1:0]      norm_lzc;
    logic [FRAC_WIDTH-1:0]     norm_frac;
    logic                      norm_zero;
    logic signed [EXP_EXT-1:0] norm_exp;

    bf16_lzc_norm u_lzc_norm (
        .sig_i  (sum_q),
        .lzc_o  (norm_lzc),
        .frac_o (norm_frac),
        .zero_o (norm_zero)
    );

    // The shifter puts the leading one at bit 8. With a carry (lzc = 0) that
    // is a right shift by one (exp + 1); otherwise a left shift by lzc - 1.
    // Both cases reduce to exp + 1 - lzc.
    assign norm_exp = $signed({2'b00, exp_q} + EXP_EXT'(1)
                              - {{(EXP_EXT - LZC_WIDTH){1'b0}}, norm_lzc});

    // ---------------------------------------------------------------------
    // FSM next state and register updates
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        last_d      = last_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        byp_d       = byp_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_error_d = out_error_q;
        out_count_d = out_count_q;
        in_ready_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (mac_if.in_valid) begin
`ifdef BF16_MAC_UNDERFLOW_FLUSH_EN
                    opnd_d = (mac_if.in_error == ERR_UNF) ? bf16_t'('0)
                                                          : bf16_t'(mac_if.in_data);
`else
                    opnd_d = bf16_t'(mac_if.in_data);
`endif
                    last_d   = mac_if.in_last;
                    sticky_d = sticky_q | mac_if.in_error;
                    state_d  = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                // A zero on either side passes the other operand through
                // untouched, so NORM must not renormalise it.
                if (is_zero(opnd_q)) begin
                    byp_d  = 1'b1;
                    sign_d = acc_q.sign;
                    exp_d  = acc_q.exp;
                    sum_d  = {2'b00, acc_q.frac};
                end else if (is_zero(acc_q)) begin
                    byp_d  = 1'b1;
                    sign_d = opnd_q.sign;
                    exp_d  = opnd_q.exp;
                    sum_d  = {2'b00, opnd_q.frac};
                end else begin
                    byp_d  = 1'b0;
                    sign_d = add_sign;
                    exp_d  = op_a.exp;
                    sum_d  = add_mag;
                end
                state_d = ST_NORM;
            end

            ST_NORM: begin
                if (byp_q) begin
                    acc_d = {sign_q, exp_q, sum_q[FRAC_WIDTH-1:0]};
                end else if (norm_zero) begin
                    acc_d = '0;
                end else if (norm_exp >= EXP_OVF_LIM) begin
                    acc_d    = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
                    sticky_d = sticky_q | ERR_OVF;
                end else if (norm_exp <= EXP_UNF_LIM) begin
                    acc_d    = '0;
                    sticky_d = sticky_q | ERR_UNF;
                end else begin
                    acc_d = {sign_q, norm_exp[EXP_WIDTH-1:0], norm_frac};
                end
                cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                state_d = last_q ? ST_DONE : ST_IDLE;
            end

            ST_DONE: begin
                if (!out_valid_q) begin
                    // First DONE cycle: capture the result; it stays frozen
                    // until the consumer takes it.
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_error_d = encode_err(sticky_q);
                    out_count_d = cnt_q;
                end else if (mac_if.out_ready) begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_error_d = ERR_NONE;
                    out_count_d = '0;
                    acc_d       = '0;
                    sticky_d    = ERR_NONE;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            opnd_q      <= '0;
            last_q      <= 1'b0;
            sticky_q    <= ERR_NONE;
            cnt_q       <= '0;
            sum_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            byp_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_error_q <= ERR_NONE;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            last_q      <= last_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            byp_q       <= byp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_error_q <= out_error_d;
            out_count_q <= out_count_d;
        end
    end

    // in_ready is held low while reset is asserted, even though the FSM
    // already sits in IDLE.
    assign mac_if.in_ready  = in_ready_c & rst_n;
    assign mac_if.out_valid = out_valid_q;
    assign mac_if.out_data  = out_data_q;
    assign mac_if.out_error = out_error_q;
    assign mac_if.out_count = out_count_q;

endmodule

// File: tb/tb_bf16_mac_accum.sv
// -----------------------------------------------------------------------------
// tb_bf16_mac_accum
// Self-checking bench for bf16_mac_accum: a table of directed sums, hand
// sequences for back-pressure and reset, and randomized sums checked against
// an integer-arithmetic reference model. Honours BF16_MAC_UNDERFLOW_FLUSH_EN.
// -----------------------------------------------------------------------------
module tb_bf16_mac_accum;
    import bf16_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bf16_mac_accum_if bif ();

    bf16_mac_accum dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mac_if (bif.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cycle = 0;
    int hs_cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    logic [15:0] q_data[$];
    logic [1:0]  q_err[$];

    typedef struct {
        logic [15:0] t0;
        logic [1:0]  e0;
        logic        two;
        logic [15:0] t1;
        logic [15:0] exp_d;
        logic [1:0]  exp_e;
        logic [7:0]  exp_c;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: exact integer significands, truncating alignment,
    // signed integer sum, renormalised by loops.
    // ---------------------------------------------------------------------
    function automatic logic [15:0] model_add(input logic [15:0] acc, input logic [15:0] t,
                                              output logic [1:0] err);
        int ea, eb, ma, mb, d, s, e, mag, tmp;
        logic sa, sb, neg;
        err = 2'b00;
        if (t[14:0] == 15'd0) return acc;
        if (acc[14:0] == 15'd0) return t;
        sa = acc[15]; ea = int'(acc[14:7]); ma = 128 + int'(acc[6:0]);
        sb = t[15];   eb = int'(t[14:7]);   mb = 128 + int'(t[6:0]);
        if (eb > ea) begin
            tmp = ea; ea = eb; eb = tmp;
            tmp = ma; ma = mb; mb = tmp;
            neg = sa; sa = sb; sb = neg;
        end
        d  = ea - eb;
        mb = (d >= 9) ? 0 : (mb >> d);
        s  = (sa ? -ma : ma) + (sb ? -mb : mb);
        if (s == 0) return 16'h0000;
        neg = (s < 0);
        mag = neg ? -s : s;
        e   = ea;
        while (mag >= 256) begin mag = mag / 2; e++; end
        while (mag < 128)  begin mag = mag * 2; e--; end
        if (e >= 255) begin err = 2'b01; return {neg, 8'hFF, 7'h00}; end
        if (e <= 0)   begin err = 2'b10; return 16'h0000; end
        return {neg, e[7:0], mag[6:0]};
    endfunction

    function automatic void model_sum(output logic [15:0] d, output logic [1:0] e,
                                      output logic [7:0] c);
        logic [15:0] acc;
        logic [15:0] t;
        logic [1:0]  st;
        logic [1:0]  oe;
        int          n;
        acc = 16'h0000; st = 2'b00; n = 0;
        foreach (q_data[i]) begin
            t  = q_data[i];
            st = st | q_err[i];
`ifdef BF16_MAC_UNDERFLOW_FLUSH_EN
            if (q_err[i] == 2'b10) t = 16'h0000;
`endif
            acc = model_add(acc, t, oe);
            st  = st | oe;
            n++;
        end
        d = acc;
        e = st[1] ? 2'b10 : (st[0] ? 2'b01 : 2'b00);
        c = (n > 255) ? 8'hFF : 8'(n);
    endfunction

    function automatic logic [15:0] rand_term();
        int r;
        int ex;
        r = $urandom_range(0, 15);
        if (r == 0) return 16'h0000;
        if (r == 1)      ex = $urandom_range(1, 6);
        else if (r == 2) ex = $urandom_range(248, 254);
        else             ex = $urandom_range(118, 136);
        return {1'($urandom_range(0, 1)), 8'(ex), 7'($urandom_range(0, 127))};
    endfunction

    function automatic logic [1:0] rand_err();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 2'b01;
        if (r == 1) return 2'b10;
        return 2'b00;
    endfunction

    // ---------------------------------------------------------------------
    // Drivers
    // ---------------------------------------------------------------------
    task automatic send(input logic [15:0] d, input logic [1:0] e, input logic l);
        int budget = 50;
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        bif.in_error = e;
        bif.in_last  = l;
        while (!bif.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bif.in_ready) begin
            check("in_ready wait", 32'(bif.in_ready), 1);
            bif.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        hs_cycle     = cycle;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic collect(input string name, input logic [15:0] exp_d, input logic [1:0] exp_e,
                           input logic [7:0] exp_c, input int hold);
        int budget = 100;
        while (!bif.out_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bif.out_valid) begin
            check({name, " out_valid timeout"}, 32'(bif.out_valid), 1);
            return;
        end
        check({name, " latency"}, 32'(cycle - hs_cycle), 3);
        check({name, " data"},  32'(bif.out_data),  32'(exp_d));
        check({name, " error"}, 32'(bif.out_error), 32'(exp_e));
        check({name, " count"}, 32'(bif.out_count), 32'(exp_c));
        for (int k = 0; k < hold; k++) begin
            bif.in_valid = (k % 2 == 0);
            bif.in_data  = 16'h4000;
            bif.in_error = 2'b00;
            bif.in_last  = 1'b1;
            @(negedge clk);
            check($sformatf("%s hold%0d data", name, k),   32'(bif.out_data),  32'(exp_d));
            check($sformatf("%s hold%0d valid", name, k),  32'(bif.out_valid), 1);
            check($sformatf("%s hold%0d ready", name, k),  32'(bif.in_ready),  0);
        end
        bif.in_valid  = 1'b0;
        bif.in_last   = 1'b0;
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bif.out_ready = 1'b0;
        check({name, " valid drop"}, 32'(bif.out_valid), 0);
    endtask

    task automatic run_sum(input string name, input logic [15:0] exp_d, input logic [1:0] exp_e,
                           input logic [7:0] exp_c, input int hold);
        int n;
        n = q_data.size();
        for (int i = 0; i < n; i++) begin
            send(q_data[i], q_err[i], (i == n - 1));
        end
        collect(name, exp_d, exp_e, exp_c, hold);
        q_data.delete();
        q_err.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, " out_valid"}, 32'(bif.out_valid), 0);
        check({name, " out_data"},  32'(bif.out_data),  0);
        check({name, " out_error"}, 32'(bif.out_error), 0);
        check({name, " out_count"}, 32'(bif.out_count), 0);
        check({name, " in_ready"},  32'(bif.in_ready),  0);
    endtask

    // ---------------------------------------------------------------------
    // Test sequence
    // ---------------------------------------------------------------------
    initial begin
        logic [15:0] ed;
        logic [1:0]  ee;
        logic [7:0]  ec;
        int          nterms;
        int          budget;

        tbl[0]  = '{16'h3F80, 2'b00, 1'b1, 16'h4000, 16'h4040, 2'b00, 8'd2};
        tbl[1]  = '{16'h3F80, 2'b00, 1'b1, 16'hBF80, 16'h0000, 2'b00, 8'd2};
        tbl[2]  = '{16'h7F00, 2'b00, 1'b1, 16'h7F00, 16'h7F80, 2'b01, 8'd2};
`ifdef BF16_MAC_UNDERFLOW_FLUSH_EN
        tbl[3]  = '{16'h3F80, 2'b10, 1'b0, 16'h0000, 16'h0000, 2'b10, 8'd1};
`else
        tbl[3]  = '{16'h3F80, 2'b10, 1'b0, 16'h0000, 16'h3F80, 2'b10, 8'd1};
`endif
        tbl[4]  = '{16'h4000, 2'b00, 1'b1, 16'hC040, 16'hBF80, 2'b00, 8'd2};
        tbl[5]  = '{16'h00C0, 2'b00, 1'b1, 16'h8080, 16'h0000, 2'b10, 8'd2};
        tbl[6]  = '{16'h4B00, 2'b00, 1'b1, 16'h3F80, 16'h4B00, 2'b00, 8'd2};
        tbl[7]  = '{16'h3FFF, 2'b00, 1'b1, 16'h3FFF, 16'h407F, 2'b00, 8'd2};
        tbl[8]  = '{16'hFF00, 2'b00, 1'b1, 16'hFF00, 16'hFF80, 2'b01, 8'd2};
        tbl[9]  = '{16'h0000, 2'b00, 1'b1, 16'h8000, 16'h0000, 2'b00, 8'd2};
        tbl[10] = '{16'h3C01, 2'b00, 1'b1, 16'h3F80, 16'h3F81, 2'b00, 8'd2};

        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_data   = 16'h0000;
        bif.in_error  = 2'b00;
        bif.in_last   = 1'b0;
        bif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("reset release in_ready", 32'(bif.in_ready), 1);

        // Directed table.
        for (int v = 0; v < 11; v++) begin
            q_data.push_back(tbl[v].t0);
            q_err.push_back(tbl[v].e0);
            if (tbl[v].two) begin
                q_data.push_back(tbl[v].t1);
                q_err.push_back(2'b00);
            end
            run_sum($sformatf("tbl%0d", v), tbl[v].exp_d, tbl[v].exp_e, tbl[v].exp_c, 0);
        end

        // Back-pressure: result held 5 cycles, in_valid pulses ignored,
        // then the next sum starts from zero.
        q_data.push_back(16'h3F80); q_err.push_back(2'b00);
        q_data.push_back(16'h3F80); q_err.push_back(2'b00);
        run_sum("hold", 16'h4000, 2'b00, 8'd2, 5);
        q_data.push_back(16'h4000); q_err.push_back(2'b00);
        run_sum("after hold", 16'h4000, 2'b00, 8'd1, 0);

        // Reset during ALIGN of the second term.
        send(16'h3F80, 2'b00, 1'b0);
        send(16'h4000, 2'b00, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset in ALIGN");
        @(negedge clk);
        rst_n = 1'b1;
        q_data.push_back(16'h4000); q_err.push_back(2'b00);
        run_sum("after reset", 16'h4000, 2'b00, 8'd1, 0);

        // Reset while a result is being presented.
        send(16'h3F80, 2'b01, 1'b1);
        budget = 100;
        while (!bif.out_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reset in DONE pre valid", 32'(bif.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset in DONE");
        @(negedge clk);
        rst_n = 1'b1;

        // Count saturation: 257 zero terms.
        for (int i = 0; i < 257; i++) begin
            q_data.push_back(16'h0000);
            q_err.push_back(2'b00);
        end
        run_sum("saturate", 16'h0000, 2'b00, 8'hFF, 0);

        // Randomized sums against the reference model.
        for (int s = 0; s < 40; s++) begin
            nterms = $urandom_range(1, 6);
            for (int k = 0; k < nterms; k++) begin
                q_data.push_back(rand_term());
                q_err.push_back(rand_err());
            end
            model_sum(ed, ee, ec);
            run_sum($sformatf("rand%0d", s), ed, ee, ec, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bf16_mac_accum.md
Name: bf16_mac_accum

Overview:
- Downstream consumer of the bfloat16 multiplier.
- Takes a stream of bf16 products, each with its 2-bit multiplier error code, over a valid/ready handshake.
- Accumulates the products into a bf16 running sum, using truncating arithmetic with no subnormals.
- Emits the sum, a sticky error code and a term count when the term flagged `last` has been absorbed. Forms the MAC tail of the dot-product datapath.

Parameters:
- DATA_WIDTH, 16, total bf16 width
- EXP_WIDTH, 8, exponent width (bias 127)
- FRAC_WIDTH, 7, stored fraction width (hidden 1 implied)
- ERROR_WIDTH, 2, error code width: 2'b10 underflow, 2'b01 overflow, 2'b00 none
- CNT_WIDTH, 8, term counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  product term valid
- in_ready  out  1  block can accept a term
- in_data  in  DATA_WIDTH  product from multiplier
- in_error  in  ERROR_WIDTH  multiplier error code for in_data
- in_last  in  1  final term of current sum
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_WIDTH  accumulated bf16 sum
- out_error  out  ERROR_WIDTH  sticky error; underflow has priority in encoding
- out_count  out  CNT_WIDTH  terms absorbed, saturating at all-ones

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values:
  - FSM = IDLE.
  - Accumulator = 0x0000.
  - Sticky error = 0, count = 0, last flag = 0.
  - out_valid = 0, out_data = 0, out_error = 0, out_count = 0.
  - in_ready = 1 once reset is released.
- Reset asserted mid-operation aborts immediately; any partial sum is discarded.
- FSM states: IDLE, ALIGN, NORM, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, register the operand, its error and last; go to ALIGN.
  - ALIGN: in_ready=0.
    - Larger-exponent operand is A. Shift the smaller operand's 8-bit significand right by the exponent difference; a difference ≥ 9 yields 0.
    - Equal signs: add. Different signs: subtract smaller magnitude from larger.
    - Result sign follows the larger magnitude. Register a 9-bit signed-magnitude sum and the exponent.
    - Go to NORM.
  - NORM:
    - Carry out of bit 8: shift right 1 and exponent+1.
    - Otherwise: leading-zero count, shift left, exponent−count.
    - Truncate to FRAC_WIDTH.
    - Significand 0: result +0 (0x0000).
    - Exponent ≥ 255: result {sign, 8'hFF, 7'h0}; set sticky bit 0.
    - Exponent ≤ 0: result +0; set sticky bit 1.
    - Write the accumulator; count += 1 (saturating).
    - Next state is DONE if the registered last flag is set, else IDLE.
  - DONE:
    - out_valid=1; out_data, out_error and out_count are stable while !out_ready.
    - On out_ready: clear accumulator, sticky error and count; go to IDLE. out_valid drops the next cycle.
- Zero operands: exp==0 & frac==0 is treated as exact zero. The adder passes the other operand unchanged, with no error.
- Exponent 255 operands are treated numerically, with no NaN/Inf semantics.
- in_error ORs into the sticky error when the term is accepted.
- out_error encoding: bit 1 set → 2'b10, else bit 0 → 2'b01, else 2'b00.
- Timing:
  - Latency: last term accepted at edge t → out_valid high after edge t+3.
  - Throughput: one term per 3 cycles.
- in_valid while in_ready=0 is ignored; the upstream stage holds the term.

Optional Feature:
- Macro: BF16_MAC_UNDERFLOW_FLUSH_EN.
- When defined:
  - A term accepted with in_error==2'b10 is replaced by +0 before ALIGN.
  - The underflow is still recorded in the sticky error.
- When undefined: the term's in_data is added as received.

Decomposition:
- Package bf16_pkg holds:
  - bf16 field widths and exponent bias 127.
  - Error code constants ERR_NONE, ERR_OVF, ERR_UNF.
  - FSM state enum.
  - Zero-detect function.
- One sub-module: bf16_lzc_norm, a combinational leading-zero count plus left shift over the 9-bit significand, used in NORM.

Test Plan:
- Terms 0x3F80, then 0x4000 with last → out_data 0x4040, out_error 00, out_count 2; out_valid 3 cycles after the last handshake.
- Terms 0x3F80, 0xBF80 (last) → out_data 0x0000, out_error 00, count 2.
- Terms 0x7F00, 0x7F00 (last) → out_data 0x7F80, out_error 01.
- Term 0x3F80 with in_error 10, last:
  - Macro off → 0x3F80, error 10.
  - Macro on → 0x0000, error 10.
- Hold out_ready=0 for 5 cycles in DONE → out_data and in_ready=0 stable; in_valid pulses ignored. out_ready=1 → next sum starts from 0.
- Assert rst_n low during ALIGN of the second term → all outputs 0 immediately. Next sum 0x4000 (last) → 0x4000, count 1.
